// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: frame handshake, status and serial line of the command-frame UART transmitter
interface uart_frame_tx_if;
    logic [23:0] frame_data_i;
    logic        frame_valid_i;
    logic        frame_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        uart_tx_o;

    modport master (
        output frame_data_i,
        output frame_valid_i,
        input  frame_ready_o,
        input  busy_o,
        input  done_o,
        input  uart_tx_o
    );

    modport slave (
        input  frame_data_i,
        input  frame_valid_i,
        output frame_ready_o,
        output busy_o,
        output done_o,
        output uart_tx_o
    );
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends FF + 24-bit payload (MSB byte first) as 8N1 bytes; UART_TX_CHECKSUM_EN appends a sum byte
module uart_frame_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_frame_tx_if.slave  bus
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef UART_TX_CHECKSUM_EN
    localparam int N_BYTES = 5;
`else
    localparam int N_BYTES = 4;
`endif
    localparam int BW = N_BYTES * 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [2:0]    r_byte, w_byte_nx;
    logic [BW-1:0] r_buf, w_buf_nx;
    logic          r_done, w_done_nx;
    logic          w_tick;
    logic          w_accept;
    logic [7:0]    w_cur;
    logic [BW-1:0] w_load;

`ifdef UART_TX_CHECKSUM_EN
    logic [7:0] w_cks;
    assign w_cks  = bus.frame_data_i[23:16] + bus.frame_data_i[15:8] + bus.frame_data_i[7:0];
    assign w_load = {8'hFF, bus.frame_data_i, w_cks};
`else
    assign w_load = {8'hFF, bus.frame_data_i};
`endif

    assign w_tick   = r_cnt == CW'(BAUD_DIV - 1);
    assign w_accept = bus.frame_valid_i && (r_state == IDLE);
    assign w_cur    = r_buf[BW-1 -: 8];

    assign bus.frame_ready_o = r_state == IDLE;
    assign bus.busy_o        = r_state != IDLE;
    assign bus.done_o        = r_done;
    assign bus.uart_tx_o     = (r_state == START) ? 1'b0 : (r_state == DATA) ? w_cur[r_bit] : 1'b1;

    // next state: the byte being sent always sits in the top of the shift buffer
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = (r_state == IDLE || w_tick) ? '0 : r_cnt + CW'(1);
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        w_buf_nx   = r_buf;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = START;
                    w_buf_nx   = w_load;
                    w_bit_nx   = '0;
                    w_byte_nx  = '0;
                end
            end
            START: w_state_nx = w_tick ? DATA : START;
            DATA: begin
                if (w_tick) begin
                    w_bit_nx   = r_bit + 3'd1;
                    w_state_nx = (r_bit == 3'd7) ? STOP : DATA;
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_byte == 3'(N_BYTES - 1)) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = START;
                        w_byte_nx  = r_byte + 3'd1;
                        w_buf_nx   = r_buf << 8;
                    end
                end
            end
        endcase
    end

    // state register; reset abandons any frame in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_buf   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_byte  <= w_byte_nx;
            r_buf   <= w_buf_nx;
            r_done  <= w_done_nx;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx at BAUD_DIV=16; honours UART_TX_CHECKSUM_EN
module tb_uart_frame_tx;
    localparam int DIV = 16;
`ifdef UART_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [23:0] data;
        logic [39:0] bytes;
    } vec_t;

    vec_t vecs [5];

    uart_frame_tx_if bus ();

    uart_frame_tx #(.BAUD_DIV(DIV)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // caller has set valid/data so the accept happens on the next rising edge
    task automatic run_frame(input logic [39:0] ex, input bit hold, input logic [23:0] nd);
        int         bad;
        int         st_bad;
        logic [7:0] dec;
        logic       e;
        st_bad = 0;
        @(negedge clk);
        if (hold) bus.frame_data_i = nd;
        else bus.frame_valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            dec = '0;
            for (int p = 0; p < 10; p++) begin
                for (int k = 0; k < DIV; k++) begin
                    if (b != 0 || p != 0 || k != 0) @(negedge clk);
                    e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : ex[31 - 8*b + p];
                    if (bus.uart_tx_o !== e) bad++;
                    if (k == DIV/2 && p >= 1 && p <= 8) dec[p-1] = bus.uart_tx_o;
                    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.frame_ready_o !== 1'b0) st_bad++;
                end
            end
            chk($sformatf("byte%0d_wave_bad_cycles", b), bad, 0);
            chk($sformatf("byte%0d_value", b), dec, ex[39 - 8*b -: 8]);
        end
        chk("status_in_frame_bad_cycles", st_bad, 0);
        @(negedge clk);
        chk("done_pulse", bus.done_o, 1);
        chk("done_cycle_busy", bus.busy_o, 0);
        chk("done_cycle_ready", bus.frame_ready_o, 1);
        chk("done_cycle_line", bus.uart_tx_o, 1);
        if (!hold) begin
            @(negedge clk);
            chk("done_single_cycle", bus.done_o, 0);
            chk("line_idle_after_frame", bus.uart_tx_o, 1);
        end
    endtask

    initial begin
        int bad;
        int dn;
        vecs[0] = '{24'h000004, 40'hFF_000004_04};
        vecs[1] = '{24'h000002, 40'hFF_000002_02};
        vecs[2] = '{24'h123456, 40'hFF_123456_9C};
        vecs[3] = '{24'hFFFF02, 40'hFF_FFFF02_00};
        vecs[4] = '{24'hA5C3F0, 40'hFF_A5C3F0_58};

        rst = 1'b1;
        bus.frame_valid_i = 1'b0;
        bus.frame_data_i  = '0;
        repeat (3) @(negedge clk);
        chk("reset_line", bus.uart_tx_o, 1);
        chk("reset_ready", bus.frame_ready_o, 1);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_done", bus.done_o, 0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.uart_tx_o !== 1'b1 || bus.frame_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        rst = 1'b1;
        bus.frame_valid_i = 1'b1;
        bus.frame_data_i  = 24'h123456;
        @(negedge clk);
        chk("rst_wins_busy", bus.busy_o, 0);
        chk("rst_wins_ready", bus.frame_ready_o, 1);
        chk("rst_wins_line", bus.uart_tx_o, 1);
        rst = 1'b0;
        bus.frame_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_wins_no_accept", bus.busy_o, 0);

        for (int i = 0; i < 5; i++) begin
            bus.frame_data_i  = vecs[i].data;
            bus.frame_valid_i = 1'b1;
            run_frame(vecs[i].bytes, 1'b0, '0);
        end

        bus.frame_data_i  = 24'h000004;
        bus.frame_valid_i = 1'b1;
        run_frame(vecs[0].bytes, 1'b1, 24'h000002);
        run_frame(vecs[1].bytes, 1'b0, '0);

        bus.frame_data_i  = 24'h000004;
        bus.frame_valid_i = 1'b1;
        @(negedge clk);
        bus.frame_valid_i = 1'b0;
        repeat (392) @(negedge clk);
        chk("pre_reset_busy", bus.busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_line", bus.uart_tx_o, 1);
        chk("mid_reset_ready", bus.frame_ready_o, 1);
        chk("mid_reset_busy", bus.busy_o, 0);
        chk("mid_reset_done", bus.done_o, 0);
        rst = 1'b0;
        bad = 0;
        dn  = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus.uart_tx_o !== 1'b1) bad++;
            if (bus.done_o !== 1'b0) dn++;
        end
        chk("after_reset_line_bad_cycles", bad, 0);
        chk("after_reset_done_pulses", dn, 0);
        bus.frame_data_i  = 24'h123456;
        bus.frame_valid_i = 1'b1;
        run_frame(vecs[2].bytes, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Command-frame UART transmitter for the `uart_top` command link: the other end of the receive path that accepts 4-byte `FF xx xx xx` command frames. It accepts a 24-bit payload through a valid/ready handshake. It serializes the payload as a header byte 0xFF followed by three payload bytes, MSB byte first. Each byte goes out 8N1, LSB first, on `uart_tx_o`.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `BAUD_DIV`, CLK_FREQ/BAUD (5208), clock cycles per bit; overridable directly for fast simulation
- `clk_i`  in  1  system clock; all logic on the rising edge
- `rst_i`  in  1  synchronous reset, active-high
- `frame_data_i`  in  24  payload; [23:16] is sent first, [7:0] last
- `frame_valid_i`  in  1  payload valid
- `frame_ready_o`  out  1  block idle, can accept a frame
- `busy_o`  out  1  a frame is in flight
- `done_o`  out  1  single-cycle pulse when the last stop bit completes
- `uart_tx_o`  out  1  serial line, idle high

## Operation
- Accept condition: `frame_valid_i && frame_ready_o` on a clock edge. On accept, the block latches {8'hFF, frame_data_i} into a shift buffer, clears byte index and bit index, and enters START.
- States and transitions:
  - IDLE: line high, ready=1. Goes to START on accept.
  - START: line 0 for BAUD_DIV cycles, then DATA.
  - DATA: line = current byte bit[n] for BAUD_DIV cycles each, n = 0..7. Goes to STOP after bit 7.
  - STOP: line 1 for BAUD_DIV cycles. If byte index < last, increment it and go to START. Otherwise pulse done_o and go to IDLE.
- Bytes are sent back to back; there is no idle gap beyond the single stop bit.
- Baud counter:
  - Width is clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1 and wraps to 0 on every bit boundary.
  - It is the only bit-timing source.
- `frame_data_i` is don't-care outside the accept cycle. Changes during a frame have no effect.
- `frame_valid_i` asserted while busy is ignored and not queued. It is accepted on the first cycle ready returns high.

## Timing
- Reset values: uart_tx_o=1, frame_ready_o=1, busy_o=0, done_o=0, state IDLE, counters 0.
- Accept on edge k: from edge k+1, ready=0, busy=1 and uart_tx_o=0 (start bit). The first line transition is one cycle after accept.
- Frame duration: N_BYTES*10*BAUD_DIV cycles from the first start-bit cycle, where N_BYTES=4 (5 with checksum). With defaults this is 208_320 cycles (4,166,400 ns).
- done_o is high for exactly one cycle, the cycle after the final stop-bit cycle. In that same cycle busy=0, ready=1 and the line stays high.
- valid held high continuously: the next frame is accepted in the done_o cycle. Its start bit begins one cycle later, so the minimum inter-frame idle is 1 cycle of line high beyond the stop bit.
- Reset mid-frame: on the edge where rst_i=1, uart_tx_o=1 and all outputs return to reset values. The frame is abandoned and no done_o is produced.
- rst_i and frame_valid_i high together: reset wins and the frame is not accepted.

## Configuration
- `UART_TX_CHECKSUM_EN` defined:
  - A fifth byte is appended after [7:0].
  - Value: (frame_data_i[23:16] + [15:8] + [7:0]) mod 256, computed and latched at accept.
  - The header 0xFF is excluded from the sum.
  - N_BYTES=5 and done_o follows the fifth stop bit.
- Not defined: exactly 4 bytes are sent and no checksum logic is present.

## Test plan
- BAUD_DIV=16, reset then idle 100 cycles:
  - uart_tx_o stays 1, ready=1, busy=0, done_o never pulses.
- BAUD_DIV=16, send 0x000004:
  - Decoded line bytes are FF, 00, 00, 04.
  - Every bit lasts exactly 16 cycles.
  - done_o pulses once, 640 cycles after the first start-bit cycle.
- Default BAUD_DIV=5208, send 0x000002:
  - Bit period is 104,160 ns ±20 ns.
  - Bytes are FF 00 00 02, decoded by a bench UART receiver model at 9600 baud.
- BAUD_DIV=16, valid held high with 0x000004 then 0x000002:
  - Second start bit begins exactly 1 idle cycle after done_o.
  - Line carries FF 00 00 04 FF 00 00 02.
  - valid asserted during the first frame is not double-accepted.
- BAUD_DIV=16, assert rst_i during byte 2, bit 3:
  - uart_tx_o=1 the next cycle, no done_o.
  - A new frame 0x123456 afterwards sends FF 12 34 56 cleanly.
- BAUD_DIV=16 with UART_TX_CHECKSUM_EN, send 0x123456:
  - Bytes are FF 12 34 56 9C.
  - done_o pulses 800 cycles after the first start-bit cycle.
  - Payload 0xFFFF02 gives checksum 0x00.
